multisim_server_quasi_static_push_mc: RTL and testbench

MULTISIM_SERVER_QUASI_STATIC_PUSH_MC -- requirements
Module: multisim_server_quasi_static_push_mc

---
 rtl/multisim_qs_pkg.sv | 14 +
 rtl/multisim_qs_chan_fifo.sv | 59 +++++
 rtl/multisim_server_push.sv | 22 ++
 rtl/multisim_server_quasi_static_push_mc.sv | 137 +++++++++++++
 tb/tb_multisim_server_quasi_static_push_mc.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multisim_qs_pkg.sv
// Shared types and helpers for the quasi-static multi-channel push server.
package multisim_qs_pkg;

  typedef enum logic [0:0] {
    QS_OVERWRITE = 1'b0,
    QS_RETRY     = 1'b1
  } qs_overflow_mode_e;

  // Width of the channel index carried in the payload MSBs (never zero).
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_qs_chan_fifo.sv
// Per-channel update queue with simultaneous push/pop when full and in-place tail overwrite.
module multisim_qs_chan_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             overwrite_tail,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop, do_push, do_ovw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign do_ovw  = overwrite_tail && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // The tail is the most recently written slot, one behind the write pointer.
  always_ff @(posedge clk) begin
    if (do_push)     mem[wr_ptr]          <= din;
    else if (do_ovw) mem[ptr_dec(wr_ptr)] <= din;
  end

endmodule

// File: rtl/multisim_server_push.sv
// Push transport: forwards a valid/ready stream to the link once a server name is configured.
module multisim_server_push #(
  parameter int DATA_WIDTH = 64
) (
  input  string                  server_name,
  input  logic                   data_vld,
  output logic                   data_rdy,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   push_vld,
  input  logic                   push_rdy,
  output logic [DATA_WIDTH-1:0]  push_data
);

  logic connected;

  // Without a server name there is nobody to push to, so the sender is held off.
  assign connected = (server_name.len() != 0);
  assign push_vld  = data_vld;
  assign push_data = data;
  assign data_rdy  = push_rdy && connected;

endmodule

// File: rtl/multisim_server_quasi_static_push_mc.sv
// Watches several quasi-static channels and pushes {channel, value} on every change, round-robin.
module multisim_server_quasi_static_push_mc
  import multisim_qs_pkg::*;
#(
  parameter int                DATA_WIDTH    = 64,
  parameter int                NUM_CHANNELS  = 4,
  parameter int                DEPTH         = 8,
  parameter qs_overflow_mode_e OVERFLOW_MODE = QS_OVERWRITE
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  string                                      server_name,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         data,
  input  logic                                       rdy,
  output logic                                       data_vld,
  output logic [ch_w(NUM_CHANNELS)+DATA_WIDTH-1:0]   payload,
  output logic [31:0]                                overflow_cnt,
  output logic                                       busy
);

  localparam int CH_W = ch_w(NUM_CHANNELS);
  localparam int PL_W = CH_W + DATA_WIDTH;

  logic                    init_q;
  logic [CH_W-1:0]         rr_ptr;
  logic [NUM_CHANNELS-1:0] q_push, q_pop, q_ovw, q_full, q_empty, ovf;
  logic [DATA_WIDTH-1:0]   q_dout [NUM_CHANNELS];
  logic                    gnt_vld;
  logic [CH_W-1:0]         gnt;
  logic [CH_W:0]           idx_sum;
  logic                    load, tx_rdy;
  logic                    vld_p1;
  logic [PL_W-1:0]         payload_p1;

  function automatic logic [31:0] count_ones(input logic [NUM_CHANNELS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] g);
    return (g == CH_W'(NUM_CHANNELS - 1)) ? '0 : g + CH_W'(1);
  endfunction

  // Stage p0: change detection and per-channel queueing
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [DATA_WIDTH-1:0] cur, prev;
    logic                  chg, blocked;

    assign cur         = data[ch*DATA_WIDTH +: DATA_WIDTH];
    assign chg         = init_q || (cur != prev);
    assign blocked     = q_full[ch] && !q_pop[ch];
    assign q_push[ch]  = chg && !blocked;
    assign q_ovw[ch]   = chg && blocked && (OVERFLOW_MODE == QS_OVERWRITE);
    assign ovf[ch]     = chg && blocked;
    assign q_pop[ch]   = load && gnt_vld && (gnt == CH_W'(ch));

    // In retry mode prev is left stale so the change keeps being seen.
    always_ff @(posedge clk) begin
      if (q_push[ch] || q_ovw[ch]) prev <= cur;
    end

    multisim_qs_chan_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (q_push[ch]),
      .pop            (q_pop[ch]),
      .overwrite_tail (q_ovw[ch]),
      .din            (cur),
      .dout           (q_dout[ch]),
      .full           (q_full[ch]),
      .empty          (q_empty[ch])
    );
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx_sum = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx_sum >= (CH_W+1)'(NUM_CHANNELS)) idx_sum = idx_sum - (CH_W+1)'(NUM_CHANNELS);
      if (!gnt_vld && !q_empty[idx_sum[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx_sum[CH_W-1:0];
      end
    end
  end

  assign load = !vld_p1 || tx_rdy;

  // Stage p1: one-entry output register feeding the transport
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      rr_ptr       <= '0;
      init_q       <= 1'b1;
      overflow_cnt <= '0;
    end else begin
      init_q       <= 1'b0;
      overflow_cnt <= sat_add(overflow_cnt, count_ones(ovf));
      if (load) begin
        vld_p1 <= gnt_vld;
        if (gnt_vld) rr_ptr <= rr_next(gnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load && gnt_vld) payload_p1 <= {gnt, q_dout[gnt]};
  end

  assign busy = vld_p1 || !(&q_empty);

  multisim_server_push #(
    .DATA_WIDTH (PL_W)
  ) u_push (
    .server_name (server_name),
    .data_vld    (vld_p1),
    .data_rdy    (tx_rdy),
    .data        (payload_p1),
    .push_vld    (data_vld),
    .push_rdy    (rdy),
    .push_data   (payload)
  );

endmodule

// File: tb/tb_multisim_server_quasi_static_push_mc.sv
// Bench: overwrite and retry instances side by side against a queue-based reference model.
module tb_multisim_server_quasi_static_push_mc;
  import multisim_qs_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int DW = 64;
  localparam int PW = 66;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rdy = 1'b0;
  string         name = "qs_bench";
  logic [DW-1:0] dv [N];
  logic [N*DW-1:0] data_bus;
  logic          vld_o, vld_r, busy_o, busy_r;
  logic [PW-1:0] pl_o, pl_r;
  logic [31:0]   ovf_o, ovf_r;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 = overwrite instance, 1 = retry instance
  logic [DW-1:0] mq [2][N][$];
  logic [DW-1:0] mprev [2][N];
  bit            mv [2];
  int            mch [2];
  logic [DW-1:0] mval [2];
  int            mrr [2];
  logic [31:0]   movf [2];
  bit            minit [2];
  logic [PW-1:0] log_q [2][$];

  always #5 clk = ~clk;
  assign data_bus = {dv[3], dv[2], dv[1], dv[0]};

  multisim_server_quasi_static_push_mc #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(N), .DEPTH(D), .OVERFLOW_MODE(QS_OVERWRITE)
  ) u_ovw (
    .clk(clk), .rst_n(rst_n), .server_name(name), .data(data_bus), .rdy(rdy),
    .data_vld(vld_o), .payload(pl_o), .overflow_cnt(ovf_o), .busy(busy_o)
  );

  multisim_server_quasi_static_push_mc #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(N), .DEPTH(D), .OVERFLOW_MODE(QS_RETRY)
  ) u_rty (
    .clk(clk), .rst_n(rst_n), .server_name(name), .data(data_bus), .rdy(rdy),
    .data_vld(vld_r), .payload(pl_r), .overflow_cnt(ovf_r), .busy(busy_r)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < N; ch++) mq[m][ch].delete();
      mv[m] = 0; mrr[m] = 0; movf[m] = '0; minit[m] = 1;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit found;
      if (!mv[m] || rdy) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (mrr[m] + i) % N;
          if (!found && mq[m][c].size() > 0) begin
            found = 1;
            mch[m] = c;
            mval[m] = mq[m][c].pop_front();
            mrr[m] = (c + 1) % N;
          end
        end
        mv[m] = found;
      end
      for (int ch = 0; ch < N; ch++) begin
        if (minit[m] || dv[ch] != mprev[m][ch]) begin
          if (mq[m][ch].size() < D) begin
            mq[m][ch].push_back(dv[ch]);
            mprev[m][ch] = dv[ch];
          end else begin
            if (movf[m] != 32'hFFFF_FFFF) movf[m] = movf[m] + 1;
            if (m == 0) begin
              mq[m][ch][D-1] = dv[ch];
              mprev[m][ch] = dv[ch];
            end
          end
        end
      end
      minit[m] = 0;
    end
  endtask

  task automatic check_dut(input int m, input logic vld, input logic bsy,
                           input logic [31:0] ovf, input logic [PW-1:0] pl);
    bit mbusy;
    logic [PW-1:0] exp_pl;
    mbusy = mv[m];
    for (int ch = 0; ch < N; ch++) if (mq[m][ch].size() > 0) mbusy = 1;
    check($sformatf("vld%0d", m), vld, mv[m]);
    check($sformatf("busy%0d", m), bsy, mbusy);
    check($sformatf("ovf%0d", m), ovf, movf[m]);
    if (mv[m]) begin
      exp_pl = {2'(mch[m]), mval[m]};
      check($sformatf("payload%0d", m), pl, exp_pl);
    end
  endtask

  task automatic step();
    if (vld_o && rdy) log_q[0].push_back(pl_o);
    if (vld_r && rdy) log_q[1].push_back(pl_r);
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, vld_o, busy_o, ovf_o, pl_o);
    check_dut(1, vld_r, busy_r, ovf_r, pl_r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    log_q[0].delete();
    log_q[1].delete();
    #1;
    check("rst_vld_o", vld_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_ovf_o", ovf_o, 0);
    check("rst_vld_r", vld_r, 0);
    check("rst_busy_r", busy_r, 0);
    check("rst_ovf_r", ovf_r, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ch_deliv(input int m, input int ch, output int cnt,
                          output logic [DW-1:0] first, output logic [DW-1:0] last);
    logic [PW-1:0] e;
    cnt = 0; first = '0; last = '0;
    foreach (log_q[m][i]) begin
      e = log_q[m][i];
      if (int'(e[PW-1:DW]) == ch) begin
        if (cnt == 0) first = e[DW-1:0];
        last = e[DW-1:0];
        cnt++;
      end
    end
  endtask

  task automatic check_init_seq(input string tag);
    logic [PW-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = log_q[0][i];
      check($sformatf("%s_ch%0d", tag, i), e[PW-1:DW], i);
      check($sformatf("%s_val%0d", tag, i), e[DW-1:0], dv[i]);
    end
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] first, last;
    logic [PW-1:0] e0, e1, stall_pl;

    #2;
    // Init sequence
    for (int ch = 0; ch < N; ch++) dv[ch] = DW'(ch + 1);
    rdy = 1'b1;
    do_reset();
    repeat (8) step();
    check_init_seq("init");
    check("init_ovf", ovf_o, 0);

    // Overwrite burst on channel 0
    rdy = 1'b0;
    for (int ch = 0; ch < N; ch++) dv[ch] = DW'(64'h100 + ch);
    do_reset();
    step();
    for (int v = 5; v <= 8; v++) begin dv[0] = DW'(v); step(); end
    check("burst_ovf", ovf_o, 2);
    rdy = 1'b1;
    repeat (12) step();
    ch_deliv(0, 0, cnt, first, last);
    check("burst_first", first, 64'h100);
    check("burst_last", last, 8);
    check("burst_ovf_end", ovf_o, 2);

    // Retry with channel 0 queue full
    rdy = 1'b0;
    for (int ch = 0; ch < N; ch++) dv[ch] = DW'(64'h200 + ch);
    do_reset();
    step();
    dv[0] = 64'h21; step();
    dv[0] = 64'h22; step();
    dv[0] = 64'h9;
    repeat (3) step();
    check("retry_ovf", ovf_r, 3);
    rdy = 1'b1;
    repeat (14) step();
    ch_deliv(1, 0, cnt, first, last);
    check("retry_last", last, 9);
    check("retry_cnt", cnt, 4);

    // Fairness with every channel changing every cycle
    rdy = 1'b1;
    for (int ch = 0; ch < N; ch++) dv[ch] = DW'(ch * 16);
    do_reset();
    step();
    repeat (24) begin
      for (int ch = 0; ch < N; ch++) dv[ch] = dv[ch] + 1;
      step();
    end
    for (int m = 0; m < 2; m++) begin
      for (int i = 1; i < 16; i++) begin
        e0 = log_q[m][i-1];
        e1 = log_q[m][i];
        check($sformatf("rr%0d_%0d", m, i), e1[PW-1:DW], (int'(e0[PW-1:DW]) + 1) % N);
      end
    end

    // Stall stability
    rdy = 1'b0;
    stall_pl = {2'(mch[0]), mval[0]};
    repeat (10) begin
      for (int ch = 0; ch < N; ch++) dv[ch] = dv[ch] + 3;
      step();
      check("stall_pl", pl_o, stall_pl);
      check("stall_vld", vld_o, 1);
    end

    // Reset while loaded and stalled
    check("pre_rst_busy", busy_o, 1);
    do_reset();
    rdy = 1'b1;
    repeat (8) step();
    check_init_seq("reinit");

    // Random traffic
    repeat (400) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 9) < 3) dv[ch] = DW'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 1) == 1);
      step();
    end
    rdy = 1'b1;
    repeat (30) step();
    check("drain_busy_o", busy_o, 0);
    check("drain_busy_r", busy_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
